nn_maxpool_stream: RTL and testbench

//  Downstream stage of the two-layer conv network. Consumes both 384-bit conv outputs:
//   - 2 ports x 3 feature maps x 8x8 pixels x 2 bits.

---
 rtl/nn_pkg.sv | 12 +
 rtl/maxpool_2x2.sv | 17 +
 rtl/nn_maxpool_stream.sv | 65 ++++++
 tb/tb_nn_maxpool_stream.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared geometry constants and FSM encoding for the maxpool stage.
package nn_pkg;
  localparam int PIX_W       = 2;
  localparam int MAP_DIM     = 8;
  localparam int MAPS_PORT   = 3;
  localparam int N_MAPS      = 2 * MAPS_PORT;
  localparam int POOL_DIM    = MAP_DIM / 2;
  localparam int WIN_PER_MAP = POOL_DIM * POOL_DIM;
  localparam int PORT_W      = MAPS_PORT * MAP_DIM * MAP_DIM * PIX_W;
  localparam int OUT_W       = N_MAPS * WIN_PER_MAP * PIX_W;
  typedef enum logic [1:0] {S_IDLE, S_POOL, S_DONE} state_t;
endpackage

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: combinational unsigned max of four pixels.
module maxpool_2x2
  import nn_pkg::*;
(
  input  logic [PIX_W-1:0] i_p0,
  input  logic [PIX_W-1:0] i_p1,
  input  logic [PIX_W-1:0] i_p2,
  input  logic [PIX_W-1:0] i_p3,
  output logic [PIX_W-1:0] o_max
);
  logic [PIX_W-1:0] w_m01, w_m23;
  always_comb begin
    w_m01 = i_p0 > i_p1 ? i_p0 : i_p1;
    w_m23 = i_p2 > i_p3 ? i_p2 : i_p3;
    o_max = w_m01 > w_m23 ? w_m01 : w_m23;
  end
endmodule

// File: rtl/nn_maxpool_stream.sv
// nn_maxpool_stream: captures two conv frames and 2x2 max-pools all six maps, one window per cycle.
module nn_maxpool_stream
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PORT_W-1:0] fmap_a,
  input  logic [PORT_W-1:0] fmap_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  pool_out,
  output logic              busy
);
  state_t              r_state, w_next;
  logic [2*PORT_W-1:0] r_frame;
  logic [OUT_W-1:0]    r_pool;
  logic [2:0]          r_map_cnt;
  logic [3:0]          r_win_cnt;
  logic [9:0]          w_base;
  logic [7:0]          w_obase;
  logic                w_last;
  logic [PIX_W-1:0]    w_max;
  // top-left pixel of the window: map*128 + row(2i)*16 + col(2j)*2
  assign w_base  = {r_map_cnt, r_win_cnt[3:2], 1'b0, r_win_cnt[1:0], 2'b00};
  assign w_obase = {r_map_cnt, r_win_cnt, 1'b0};
  assign w_last  = r_map_cnt == 3'(N_MAPS - 1) && r_win_cnt == 4'(WIN_PER_MAP - 1);
  maxpool_2x2 u_max (
    .i_p0 (r_frame[w_base +: PIX_W]),
    .i_p1 (r_frame[w_base + 10'd2 +: PIX_W]),
    .i_p2 (r_frame[w_base + 10'd16 +: PIX_W]),
    .i_p3 (r_frame[w_base + 10'd18 +: PIX_W]),
    .o_max(w_max)
  );
  always_comb begin
    w_next = r_state == S_IDLE ? (in_valid  ? S_POOL : S_IDLE) :
             r_state == S_POOL ? (w_last    ? S_DONE : S_POOL) :
             r_state == S_DONE ? (out_ready ? S_IDLE : S_DONE) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_pool    <= '0;
      r_map_cnt <= '0;
      r_win_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && in_valid) begin
        r_frame   <= {fmap_b, fmap_a};
        r_map_cnt <= '0;
        r_win_cnt <= '0;
      end
      if (r_state == S_POOL) begin
        r_pool[w_obase +: PIX_W] <= w_max;
        {r_map_cnt, r_win_cnt}   <= {r_map_cnt, r_win_cnt} + 7'd1;
      end
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign busy      = r_state == S_POOL;
  assign out_valid = r_state == S_DONE;
  assign pool_out  = r_pool;
endmodule

// File: tb/tb_nn_maxpool_stream.sv
// tb_nn_maxpool_stream: directed and random frames checked against a loop-based pooling model.
module tb_nn_maxpool_stream;
  logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [383:0] fmap_a = '0, fmap_b = '0;
  logic         in_ready, out_valid, busy;
  logic [191:0] pool_out;
  int           n_vec = 0, n_err = 0;

  nn_maxpool_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmap_a(fmap_a), .fmap_b(fmap_b), .out_valid(out_valid),
    .out_ready(out_ready), .pool_out(pool_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [191:0] pool_ref(input logic [767:0] f);
    logic [191:0] r = '0;
    logic [1:0] m, p;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          m = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              p = f[128*k + 2*(8*(2*i+dr) + 2*j + dc) +: 2];
              if (p > m) m = p;
            end
          r[32*k + 2*(4*i+j) +: 2] = m;
        end
    return r;
  endfunction

  function automatic logic [383:0] rnd384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [767:0] mod_frame();
    logic [767:0] f;
    for (int k = 0; k < 6; k++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          f[128*k + 2*(8*r+c) +: 2] = 2'((8*r+c) % 4);
    return f;
  endfunction

  task automatic send_frame(input logic [383:0] a, input logic [383:0] b,
                            output logic [191:0] got, output int lat);
    @(negedge clk);
    in_valid = 1; fmap_a = a; fmap_b = b;
    @(posedge clk); #1;
    in_valid = 0; fmap_a = rnd384(); fmap_b = rnd384();
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    got = pool_out;
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || pool_out !== '0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b pool_out=%h, want 1 0 0 0",
               in_ready, out_valid, busy, pool_out);
    end
  endtask

  task automatic test_single_pixel();
    logic [383:0] a = '0;
    logic [191:0] got, exp;
    int lat;
    a[59:58] = 2'b11;
    exp = pool_ref({384'b0, a});
    send_frame(a, '0, got, lat);
    n_vec++;
    if (lat !== 96) begin n_err++; $display("FAIL single_latency: got %0d want 96", lat); end
    n_vec++;
    if (got !== exp || exp !== 192'h3000) begin
      n_err++; $display("FAIL single_pixel: got %h want %h", got, 192'h3000);
    end
    release_out();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mod_pattern();
    logic [767:0] f = mod_frame();
    logic [191:0] got, exp = '0;
    int lat;
    for (int q = 0; q < 96; q++) exp[2*q +: 2] = (q % 2) ? 2'd3 : 2'd1;
    send_frame(f[383:0], f[767:384], got, lat);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mod_pattern: got %h want %h", got, exp); end
    n_vec++;
    if (got !== pool_ref(f)) begin n_err++; $display("FAIL mod_model: got %h want %h", got, pool_ref(f)); end
    release_out();
  endtask

  task automatic test_map5_ones();
    logic [383:0] b = '0;
    logic [191:0] got, exp = '0;
    int lat;
    b[383:256] = '1;
    exp[191:160] = '1;
    send_frame('0, b, got, lat);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL map5_ones: got %h want %h", got, exp); end
    release_out();
  endtask

  task automatic test_hold();
    logic [383:0] a = rnd384(), b = rnd384();
    logic [191:0] got, exp;
    int lat;
    exp = pool_ref({b, a});
    send_frame(a, b, got, lat);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL hold_result: got %h want %h", got, exp); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = ~in_valid; fmap_a = rnd384(); fmap_b = rnd384();
      @(posedge clk); #1;
      n_vec++;
      if (pool_out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: pool_out=%h out_valid=%b in_ready=%b want %h 1 0",
                 c, pool_out, out_valid, in_ready, exp);
      end
    end
    @(negedge clk); in_valid = 0;
    release_out();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_pool();
    logic [767:0] f = mod_frame();
    logic [191:0] got;
    int lat;
    @(negedge clk);
    in_valid = 1; fmap_a = rnd384(); fmap_b = rnd384();
    @(posedge clk); #1; in_valid = 0;
    repeat (40) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_pool_busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    #1 rst = 1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || pool_out !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pool_reset: out_valid=%b busy=%b pool_out=%h in_ready=%b want 0 0 0 1",
               out_valid, busy, pool_out, in_ready);
    end
    @(negedge clk); rst = 0;
    send_frame(f[383:0], f[767:384], got, lat);
    n_vec++;
    if (got !== pool_ref(f) || lat !== 96) begin
      n_err++; $display("FAIL post_reset_frame: got %h lat %0d want %h lat 96", got, lat, pool_ref(f));
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [383:0] a, b;
    logic [191:0] got;
    int lat;
    for (int n = 0; n < 6; n++) begin
      a = rnd384(); b = rnd384();
      if (n == 0) begin a = '1; b = '1; end
      send_frame(a, b, got, lat);
      n_vec++;
      if (got !== pool_ref({b, a}) || lat !== 96) begin
        n_err++; $display("FAIL b2b_frame%0d: got %h lat %0d want %h lat 96", n, got, lat, pool_ref({b, a}));
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_mod_pattern();
    test_map5_ones();
    test_hold();
    test_reset_mid_pool();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
